adc_burst_decoder: RTL

ADC_BURST_DECODER -- requirements
Module: adc_burst_decoder

---
 rtl/adc_burst_decoder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/adc_burst_decoder.sv
// adc_burst_decoder: decodes packed ADC words into a buffered sample stream plus per-burst summaries
module adc_burst_decoder #(
   parameter int MAX_BURST_LEN = 65536
) (
   input  logic        aclk,
   input  logic        areset,
   input  logic [31:0] s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   input  logic        s_axis_tlast,
   output logic        m_sample_tvalid,
   input  logic        m_sample_tready,
   output logic [15:0] m_sample_a,
   output logic [15:0] m_sample_b,
   output logic        m_sample_detrig,
   output logic        m_sample_last,
   output logic        m_burst_valid,
   input  logic        m_burst_ready,
   output logic [31:0] m_burst_len,
   output logic [15:0] m_burst_peak,
   output logic [15:0] m_burst_detrig_cnt,
   output logic [3:0]  m_burst_err,
   input  logic        clear_stats,
   output logic [15:0] burst_count,
   output logic [15:0] error_count
);
   typedef enum logic [1:0] {IDLE, IN_BURST, SUMMARY} state_t;
   state_t      r_state, w_next;
   logic [33:0] r_mem [2];
   logic        r_wr_ptr, r_rd_ptr;
   logic [1:0]  r_cnt;
   logic [31:0] r_len;
   logic [15:0] r_peak, r_dcnt, r_burst_count, r_error_count;
   logic [3:0]  r_err;
   logic [1:0]  w_tag;
   logic [15:0] w_a, w_b, w_abs_a, w_abs_b, w_mag, w_peak_nx, w_dcnt_nx;
   logic [31:0] w_len_nx;
   logic [3:0]  w_err_nx;
   logic        w_push, w_pop, w_first, w_marker, w_det, w_at_max, w_close, w_bhs;

   assign w_tag    = s_axis_tdata[31:30];
   assign w_a      = {s_axis_tdata[29], s_axis_tdata[29:15]};
   assign w_b      = {s_axis_tdata[14], s_axis_tdata[14:0]};
   // magnitudes of 15-bit values never exceed 16384, so the 16-bit unsigned sum cannot overflow
   assign w_abs_a  = w_a[15] ? 16'(-w_a) : w_a;
   assign w_abs_b  = w_b[15] ? 16'(-w_b) : w_b;
   assign w_mag    = w_abs_a + w_abs_b;
   assign w_marker = w_tag == 2'b11;
   assign w_det    = w_tag == 2'b10;

   // ready depends only on registered state; reset gates it low while the registers are held clear
   assign s_axis_tready   = !areset && r_cnt != 2'd2 && r_state != SUMMARY;
   assign w_push          = s_axis_tvalid & s_axis_tready;
   assign m_sample_tvalid = r_cnt != 2'd0;
   assign w_pop           = m_sample_tvalid & m_sample_tready;
   assign {m_sample_last, m_sample_detrig, m_sample_a, m_sample_b} = r_mem[r_rd_ptr];

   assign w_first   = r_state == IDLE;
   assign w_len_nx  = w_first ? 32'd1 : r_len + 32'd1;
   assign w_at_max  = w_len_nx >= 32'(MAX_BURST_LEN);
   assign w_close   = s_axis_tlast | w_marker | w_at_max;
   assign w_peak_nx = (w_first || w_mag > r_peak) ? w_mag : r_peak;
   assign w_dcnt_nx = w_first ? {15'd0, w_det} : (&r_dcnt ? r_dcnt : r_dcnt + {15'd0, w_det});
   assign w_err_nx  = (w_first ? 4'd0 : r_err) |
                      {w_tag == 2'b01, w_at_max & ~s_axis_tlast & ~w_marker,
                       s_axis_tlast & ~w_marker, w_marker & ~s_axis_tlast};
   assign w_bhs     = r_state == SUMMARY && m_burst_ready;

   assign m_burst_valid      = r_state == SUMMARY;
   assign m_burst_len        = r_len;
   assign m_burst_peak       = r_peak;
   assign m_burst_detrig_cnt = r_dcnt;
   assign m_burst_err        = r_err;
   assign burst_count        = r_burst_count;
   assign error_count        = r_error_count;

   // burst state register
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // next state: summary waits for its handshake, otherwise each accepted word opens or closes a burst
   always_comb begin
      w_next = r_state;
      if (r_state == SUMMARY) w_next = m_burst_ready ? IDLE : SUMMARY;
      else if (w_push)        w_next = w_close ? SUMMARY : IN_BURST;
   end

   // two-entry sample FIFO; the closing word carries the last flag
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_cnt    <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= {w_close, w_tag[1], w_a, w_b};
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) r_rd_ptr <= ~r_rd_ptr;
         r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   // burst accumulators, frozen while the summary is presented
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_len  <= '0;
         r_peak <= '0;
         r_dcnt <= '0;
         r_err  <= '0;
      end else if (w_push) begin
         r_len  <= w_len_nx;
         r_peak <= w_peak_nx;
         r_dcnt <= w_dcnt_nx;
         r_err  <= w_err_nx;
      end
   end

   // closed-burst statistics; clear wins over a coincident handshake
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_burst_count <= '0;
         r_error_count <= '0;
      end else if (clear_stats) begin
         r_burst_count <= '0;
         r_error_count <= '0;
      end else if (w_bhs) begin
         r_burst_count <= r_burst_count + 16'd1;
         r_error_count <= r_error_count + {15'd0, |r_err};
      end
   end
endmodule
